// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the nibble-serial ALU sequencer.
//   - ALU operation encodings (the same values driven onto the ALU S lines)
//   - sequencer state enum
//   - nibble width of the external combinational ALU
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int NIB_W = 4;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_nibble_seq.sv
// -----------------------------------------------------------------------------
// alu_nibble_seq
// Drives an external 4-bit combinational ALU one nibble per cycle (LSB nibble
// first) to perform AND/OR/XOR/ADD on W = 4*NIBBLES bit operands. For ADD the
// ALU carry-out of each nibble feeds the carry-in of the next. The assembled
// result plus carry/zero flags are offered on a valid/ready output.
//
// Parameters:
//   NIBBLES   number of 4-bit passes (1..8)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (ready only in IDLE)
//   in_a, in_b         W-bit operands, sampled on the firing edge only
//   in_cin             carry-in of the least-significant nibble (ADD only)
//   in_op              00 AND, 01 OR, 10 XOR, 11 ADD
//   alu_a/b/cin/s      drive to the external ALU (all 0 outside RUN)
//   alu_f, alu_cout    ALU results
//   out_valid/ready    result handshake (valid only in DONE)
//   out_f              W-bit result
//   out_cout           final carry for ADD, else 0
//   out_zero           out_f == 0 (registered with the final nibble)
//   out_ovf            signed overflow for ADD (only with ALU_SEQ_OVF_EN)
//
// Build option: define ALU_SEQ_OVF_EN to add the out_ovf port and logic.
// -----------------------------------------------------------------------------
module alu_nibble_seq
   import alu_seq_pkg::*;
#(
   parameter int NIBBLES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIB_W*NIBBLES-1:0] in_a,
   input  logic [NIB_W*NIBBLES-1:0] in_b,
   input  logic                     in_cin,
   input  logic [1:0]               in_op,
   output logic [NIB_W-1:0]         alu_a,
   output logic [NIB_W-1:0]         alu_b,
   output logic                     alu_cin,
   output logic [1:0]               alu_s,
   input  logic [NIB_W-1:0]         alu_f,
   input  logic                     alu_cout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIB_W*NIBBLES-1:0] out_f,
   output logic                     out_cout,
   output logic                     out_zero
`ifdef ALU_SEQ_OVF_EN
   ,
   output logic                     out_ovf
`endif
);

   localparam int W     = NIB_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             carry_r;
   logic [W-1:0]     a_r;
   logic [W-1:0]     b_r;
   logic             cin_r;
   logic [1:0]       op_r;

   logic             run;
   logic             is_add;
   logic             last;
   logic [W-1:0]     res_next;

   assign run       = (state == RUN);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign is_add    = (op_r == OP_ADD);
   assign last      = (idx == IDX_LAST);

   // ALU drive: only meaningful in RUN, forced to 0 elsewhere so the ALU
   // inputs are quiet while idle or holding a result.
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_cin = 1'b0;
      alu_s   = 2'b00;
      if (run) begin
         alu_a = a_r[NIB_W*int'(idx) +: NIB_W];
         alu_b = b_r[NIB_W*int'(idx) +: NIB_W];
         alu_s = op_r;
         if (is_add)
            alu_cin = (idx == '0) ? cin_r : carry_r;
      end
   end

   // Result with the current ALU nibble merged in; on the last pass this is
   // the complete result, which is what the zero/overflow flags look at.
   always_comb begin
      res_next = out_f;
      res_next[NIB_W*int'(idx) +: NIB_W] = alu_f;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         carry_r  <= 1'b0;
         a_r      <= '0;
         b_r      <= '0;
         cin_r    <= 1'b0;
         op_r     <= OP_AND;
         out_f    <= '0;
         out_cout <= 1'b0;
         out_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= in_a;
                  b_r      <= in_b;
                  cin_r    <= in_cin;
                  op_r     <= in_op;
                  out_f    <= '0;
                  out_cout <= 1'b0;
                  out_zero <= 1'b0;
                  // no carry leaks in from a previous operation
                  carry_r  <= 1'b0;
                  idx      <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               out_f <= res_next;
               // ALU carry-out is undefined for logic ops; never sample it
               carry_r <= is_add ? alu_cout : 1'b0;
               if (last) begin
                  idx      <= '0;
                  out_cout <= is_add ? alu_cout : 1'b0;
                  out_zero <= (res_next == '0);
                  state    <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_OVF_EN
   // Signed overflow: operands agree in sign but the sum does not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_ovf <= 1'b0;
      end else begin
         if (state == IDLE && in_valid)
            out_ovf <= 1'b0;
         else if (run && last)
            out_ovf <= is_add && (a_r[W-1] == b_r[W-1]) &&
                       (res_next[W-1] != a_r[W-1]);
      end
   end
`endif

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle sequencer directly upstream of the 4-bit combinational ALU (ports A, B, Cin, S → F, Cout).
- Performs AND/OR/XOR/ADD on operands 4*NIBBLES bits wide by driving the ALU one nibble per cycle, LSB nibble first.
- For ADD, the ALU Cout of each nibble becomes the Cin of the next nibble.
- Collects ALU results into a wide result register with carry and zero flags, and presents them on a valid/ready output.
- The ALU instance stays external and is wired up at the parent level.

Parameters:
- NIBBLES, 2, number of 4-bit passes; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  sequencer can accept; high only in IDLE
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cin  input  1  carry-in of least-significant nibble (ADD only)
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 ADD
- alu_a  output  4  to ALU A
- alu_b  output  4  to ALU B
- alu_cin  output  1  to ALU Cin
- alu_s  output  2  to ALU S
- alu_f  input  4  from ALU F
- alu_cout  input  1  from ALU Cout
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_f  output  W  result
- out_cout  output  1  final carry (ADD), else 0
- out_zero  output  1  out_f == 0

Behaviour:
- States: IDLE, RUN, DONE. Reset is asynchronous: state=IDLE, nibble index idx=0, carry register=0, operand registers=0, out_f=0, out_cout=0, out_zero=0.
- Outputs during and after reset: in_ready=1 (decoded from IDLE), out_valid=0, alu_a/alu_b/alu_cin/alu_s all 0.
- IDLE:
  - Fire when in_valid && in_ready.
  - On fire: latch in_a, in_b, in_cin, in_op; clear the result register; idx=0; go to RUN.
- RUN, combinational drive each cycle:
  - alu_a = A[4*idx+3:4*idx]; alu_b = B[4*idx+3:4*idx]; alu_s = latched op.
  - alu_cin = latched cin when idx==0, otherwise the carry register. For non-ADD ops, alu_cin=0.
- RUN, at each clock edge:
  - Write alu_f into result nibble idx.
  - Carry register <= alu_cout for ADD, otherwise 0. alu_cout is never sampled for non-ADD ops, because the ALU leaves it unassigned there.
  - idx++.
  - When idx==NIBBLES-1: go to DONE and load out_cout from that final alu_cout (ADD) or 0.
- DONE:
  - out_valid=1; out_f, out_cout and out_zero are held stable.
  - ALU drive lines return to 0.
  - out_valid && out_ready → IDLE, with out_valid=0 next cycle.
- Timing:
  - Latency: fire at edge k → out_valid high after edge k+NIBBLES.
  - No overlap: minimum NIBBLES+2 cycles per operation.
- in_valid is ignored outside IDLE. Operands must be held only for the firing cycle.
- out_zero is registered and derived from the complete result: set with the final nibble write, not per nibble.
- Carry out of the top nibble is never wrapped into the next operation. The carry register is cleared on every fire.
- Reset asserted mid-RUN or in DONE aborts the operation and returns to IDLE; the partial result is discarded.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), reset value 0, loaded alongside out_cout.
  - For ADD, out_ovf = (A[W-1]==B[W-1]) && (result[W-1]!=A[W-1]). For other ops it is 0.
  - It is held through DONE.
- Undefined: no port and no logic.

Decomposition:
- Package alu_seq_pkg holds:
  - op encodings: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11;
  - the state enum: IDLE, RUN, DONE;
  - the nibble width constant NIB_W=4.
- No sub-module: the index counter and result register are small enough to live in the top.

Test Plan (NIBBLES=2, bench models the 4-bit ALU):
- Reset held, then released → in_ready=1, out_valid=0, alu_s=0, out_f=0x00 before any request.
- ADD 0x3C+0x4F, cin=0 → low pass 0xC+0xF gives 0xB with carry 1 → out_f=0x8B, out_cout=0, out_zero=0, out_ovf=1 (macro on); out_valid exactly 2 cycles after fire.
- ADD 0xFF+0x01, cin=0 → out_f=0x00, out_cout=1, out_zero=1, out_ovf=0. Then ADD 0x00+0x00, cin=1 → out_f=0x01, out_cout=0, which checks that the carry register was cleared on fire.
- XOR 0xA5^0xA5 with the ALU model driving alu_cout=1/X → out_f=0x00, out_zero=1, out_cout=0; alu_cin=0 on both passes.
- Backpressure: out_ready low for 5 cycles in DONE with in_valid pulsed → out_f/flags stable, in_ready=0, no second fire. Then out_ready=1 → IDLE; the next in_valid fires.
- rst_n pulsed low after the first RUN nibble of AND 0xF0&0x3C → immediately in_ready=1, out_valid=0. Then OR 0x12|0x41 → out_f=0x53, correct.
